// File: rtl/beinmotion_qsys_sysid_ext.sv
// beinmotion_qsys_sysid_ext
// System-ID / uptime peripheral on the Qsys control bus (Avalon-MM slave,
// fixed read latency of one cycle, no waitrequest).
//
// Ports:
//   clock          system clock
//   reset_n        asynchronous active-low reset
//   address[2:0]   word address (fully decoded, 8 words)
//   read, write    single-cycle access strobes; read wins when both are high
//   writedata      write data
//   byteenable     write byte lanes
//   readdata       registered read data, held until the next read
//   readdatavalid  one-cycle pulse alongside readdata
//   tick           one-cycle pulse per uptime increment
//
// Word map: 0 ID, 1 TIMESTAMP, 2 VERSION, 3 SCRATCH, 4 UPTIME_LO,
//           5 UPTIME_HI (shadow), 6 CTRL {OVF[8], CLR[1], EN[0]}, 7 PRESCALE.
//
// UPTIME_RESET is the counter's reset value. It is 0 in every real build;
// simulation overrides it to start the counter close to a carry or a wrap.

module beinmotion_qsys_sysid_ext #(
    parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'd1358911882,
    parameter logic [31:0] VERSION      = 32'h0001_0000,
    parameter int          UPTIME_W     = 48,
    parameter int          PRESCALE     = 50,
    parameter logic [63:0] UPTIME_RESET = 64'd0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        tick
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int HI_W = UPTIME_W - 32;

    logic [PS_W-1:0]     ps_cnt;
    logic [UPTIME_W-1:0] uptime;
    logic [HI_W-1:0]     shadow;
    logic [31:0]         scratch;
    logic                en;
    logic                ovf;

    logic                wr_en;
    logic                ctrl_wr;
    logic                clr;
    logic                ovf_clr;
    logic                ps_last;
    logic                tick_evt;
    logic [31:0]         rd_mux;

    // A write that coincides with a read is dropped.
    assign wr_en    = write & ~read;
    assign ctrl_wr  = wr_en & (address == 3'd6);
    assign clr      = ctrl_wr & byteenable[0] & writedata[1];
    assign ovf_clr  = ctrl_wr & byteenable[1] & writedata[8];
    assign ps_last  = (ps_cnt == PS_W'(PRESCALE - 1));
    assign tick_evt = en & ps_last;

    always_comb begin
        rd_mux = 32'd0;
        case (address)
            3'd0:    rd_mux = SYSTEM_ID;
            3'd1:    rd_mux = TIMESTAMP;
            3'd2:    rd_mux = VERSION;
            3'd3:    rd_mux = scratch;
            3'd4:    rd_mux = uptime[31:0];
            3'd5:    rd_mux = 32'(shadow);
            3'd6:    rd_mux = {23'd0, ovf, 6'd0, 1'b0, en};
            3'd7:    rd_mux = 32'(PRESCALE);
            default: rd_mux = 32'd0;
        endcase
    end

    // Prescaler and uptime counter. CLR overrides a coincident increment,
    // but the tick pulse for that increment is still emitted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ps_cnt <= '0;
            uptime <= UPTIME_RESET[UPTIME_W-1:0];
            tick   <= 1'b0;
        end else begin
            tick <= tick_evt;
            if (clr) begin
                ps_cnt <= '0;
                uptime <= '0;
            end else if (en) begin
                ps_cnt <= ps_last ? '0 : ps_cnt + PS_W'(1);
                if (ps_last) begin
                    uptime <= uptime + UPTIME_W'(1);
                end
            end
        end
    end

    // Control/status and scratch. An overflow set beats a same-cycle clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            en      <= 1'b1;
            ovf     <= 1'b0;
            scratch <= 32'd0;
        end else begin
            if (tick_evt && (&uptime) && !clr) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (ctrl_wr && byteenable[0]) begin
                en <= writedata[0];
            end
            if (wr_en && (address == 3'd3)) begin
                for (int b = 0; b < 4; b++) begin
                    if (byteenable[b]) begin
                        scratch[8*b +: 8] <= writedata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read path. A LO read latches the upper bits from the same sample so a
    // following HI read is coherent with it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata      <= 32'd0;
            readdatavalid <= 1'b0;
            shadow        <= '0;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= rd_mux;
                if (address == 3'd4) begin
                    shadow <= uptime[UPTIME_W-1:32];
                end
            end
        end
    end

endmodule

// File: tb/tb_beinmotion_qsys_sysid_ext.sv
module tb_beinmotion_qsys_sysid_ext;

    localparam int          NI            = 4;
    localparam int          PS   [NI]     = '{50, 4, 1, 1};
    localparam int          UW   [NI]     = '{48, 48, 48, 33};
    localparam logic [63:0] INIT [NI]     = '{64'd0, 64'd0, 64'h0000_FFFF_FFF0, 64'h1_FFFF_FFEC};
    localparam logic [31:0] TS_VAL        = 32'd1358911882;
    localparam logic [31:0] VER_VAL       = 32'h0001_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address    [NI];
    logic        rd         [NI];
    logic        wr         [NI];
    logic [31:0] wdata      [NI];
    logic [3:0]  be         [NI];
    logic [31:0] readdata   [NI];
    logic        rdv        [NI];
    logic        tick       [NI];

    always #5 clock = ~clock;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        beinmotion_qsys_sysid_ext #(
            .SYSTEM_ID   (32'h0000_0000),
            .TIMESTAMP   (TS_VAL),
            .VERSION     (VER_VAL),
            .UPTIME_W    (UW[g]),
            .PRESCALE    (PS[g]),
            .UPTIME_RESET(INIT[g])
        ) u_dut (
            .clock        (clock),
            .reset_n      (reset_n),
            .address      (address[g]),
            .read         (rd[g]),
            .write        (wr[g]),
            .writedata    (wdata[g]),
            .byteenable   (be[g]),
            .readdata     (readdata[g]),
            .readdatavalid(rdv[g]),
            .tick         (tick[g])
        );
    end

    // Behavioural model: uptime is derived from the number of enabled clock
    // edges since reset/clear, divided by the prescale ratio.
    bit              m_en     [NI];
    bit              m_ovf    [NI];
    bit              m_rdv    [NI];
    logic [31:0]     m_scr    [NI];
    logic [31:0]     m_shadow [NI];
    logic [31:0]     m_rd     [NI];
    longint unsigned m_cnt    [NI];
    logic [63:0]     m_init   [NI];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        r;
        logic        w;
        logic [2:0]  a;
        logic [31:0] d;
        logic [3:0]  b;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [63:0] mask(int k);
        return (64'd1 << UW[k]) - 64'd1;
    endfunction

    function automatic logic [63:0] mdl_uptime(int k);
        return (m_init[k] + m_cnt[k] / 64'(PS[k])) & mask(k);
    endfunction

    function automatic logic [31:0] reg_val(int k, logic [2:0] a, logic [63:0] cur);
        case (a)
            3'd0:    return 32'h0000_0000;
            3'd1:    return TS_VAL;
            3'd2:    return VER_VAL;
            3'd3:    return m_scr[k];
            3'd4:    return cur[31:0];
            3'd5:    return m_shadow[k];
            3'd6:    return (m_ovf[k] ? 32'h100 : 32'h0) | (m_en[k] ? 32'h1 : 32'h0);
            default: return 32'(PS[k]);
        endcase
    endfunction

    function automatic vec_t mk(logic r, logic w, logic [2:0] a, logic [31:0] d,
                                logic [3:0] b, logic chk, logic [31:0] exp);
        vec_t v;
        v.r = r; v.w = w; v.a = a; v.d = d; v.b = b; v.chk = chk; v.exp = exp;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        for (int k = 0; k < NI; k++) begin
            address[k] = 3'd0; rd[k] = 1'b0; wr[k] = 1'b0;
            wdata[k] = 32'd0;  be[k] = 4'd0;
        end
    endtask

    task automatic drive(int k, bit r, bit w, logic [2:0] a, logic [31:0] d, logic [3:0] b);
        address[k] = a; rd[k] = r; wr[k] = w; wdata[k] = d; be[k] = b;
    endtask

    task automatic model_init();
        for (int k = 0; k < NI; k++) begin
            m_en[k] = 1'b1;     m_ovf[k] = 1'b0;    m_rdv[k] = 1'b0;
            m_scr[k] = 32'd0;   m_shadow[k] = 32'd0; m_rd[k] = 32'd0;
            m_cnt[k] = 0;       m_init[k] = INIT[k];
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        idle_all();
        model_init();
        repeat (2) @(posedge clock);
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_readdata[%0d]", k), 64'(readdata[k]), 64'd0);
            check($sformatf("rst_rdv[%0d]", k), 64'(rdv[k]), 64'd0);
            check($sformatf("rst_tick[%0d]", k), 64'(tick[k]), 64'd0);
        end
        reset_n = 1'b1;
    endtask

    // One clock edge: predict from the inputs currently on the buses, then
    // compare every instance's outputs 1 time unit after the edge.
    task automatic step();
        bit t_exp [NI];
        for (int k = 0; k < NI; k++) begin
            logic [63:0] cur;
            bit w, cw, clr, wrapped;
            cur = mdl_uptime(k);
            w   = wr[k] && !rd[k];
            cw  = w && (address[k] == 3'd6);
            if (rd[k]) begin
                m_rd[k] = reg_val(k, address[k], cur);
                if (address[k] == 3'd4) m_shadow[k] = 32'(cur >> 32);
            end
            m_rdv[k] = rd[k];
            t_exp[k] = m_en[k] && (((m_cnt[k] + 1) % 64'(PS[k])) == 0);
            wrapped  = t_exp[k] && (cur == mask(k));
            clr      = cw && be[k][0] && wdata[k][1];
            if (clr) begin
                m_cnt[k]  = 0;
                m_init[k] = 64'd0;
            end else if (m_en[k]) begin
                m_cnt[k]++;
            end
            if (wrapped && !clr) m_ovf[k] = 1'b1;
            else if (cw && be[k][1] && wdata[k][8]) m_ovf[k] = 1'b0;
            if (cw && be[k][0]) m_en[k] = wdata[k][0];
            if (w && address[k] == 3'd3)
                for (int b = 0; b < 4; b++)
                    if (be[k][b]) m_scr[k][8*b +: 8] = wdata[k][8*b +: 8];
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rdv[%0d]", k), 64'(rdv[k]), 64'(m_rdv[k]));
            check($sformatf("tick[%0d]", k), 64'(tick[k]), 64'(t_exp[k]));
            check($sformatf("readdata[%0d]", k), 64'(readdata[k]), 64'(m_rd[k]));
        end
        idle_all();
    endtask

    initial begin
        logic [31:0] lo, hi;
        logic [63:0] sample;

        do_reset();

        // Prescaler timing on the PRESCALE=4 instance, tick checked every edge.
        repeat (40) step();
        drive(1, 1, 0, 3'd4, 32'd0, 4'd0); step();
        check("lo_after_40", 64'(readdata[1]), 64'd10);
        drive(1, 0, 1, 3'd6, 32'h0, 4'b0001); step();
        repeat (20) step();
        drive(1, 1, 0, 3'd4, 32'd0, 4'd0); step();
        check("lo_frozen", 64'(readdata[1]), 64'd10);
        drive(1, 0, 1, 3'd6, 32'h1, 4'b0001); step();

        // CLR coinciding with a tick.
        for (int i = 0; i < 8 && ((m_cnt[1] + 1) % 4) != 0; i++) step();
        drive(1, 0, 1, 3'd6, 32'h3, 4'b0001); step();
        drive(1, 1, 0, 3'd4, 32'd0, 4'd0); step();
        check("lo_after_clr", 64'(readdata[1]), 64'd0);

        // Register map on instance 0.
        tbl.push_back(mk(1, 0, 3'd0, 32'd0,         4'h0, 1, 32'h0000_0000));
        tbl.push_back(mk(1, 0, 3'd1, 32'd0,         4'h0, 1, 32'd1358911882));
        tbl.push_back(mk(1, 0, 3'd2, 32'd0,         4'h0, 1, 32'h0001_0000));
        tbl.push_back(mk(1, 0, 3'd7, 32'd0,         4'h0, 1, 32'd50));
        tbl.push_back(mk(1, 0, 3'd3, 32'd0,         4'h0, 1, 32'h0000_0000));
        tbl.push_back(mk(1, 0, 3'd6, 32'd0,         4'h0, 1, 32'h0000_0001));
        tbl.push_back(mk(1, 0, 3'd5, 32'd0,         4'h0, 1, 32'h0000_0000));
        tbl.push_back(mk(0, 1, 3'd3, 32'hA5A5_A5A5, 4'hF, 0, 32'd0));
        tbl.push_back(mk(0, 1, 3'd3, 32'h0000_0000, 4'h4, 0, 32'd0));
        tbl.push_back(mk(1, 0, 3'd3, 32'd0,         4'h0, 1, 32'hA500_A5A5));
        tbl.push_back(mk(0, 1, 3'd0, 32'hFFFF_FFFF, 4'hF, 0, 32'd0));
        tbl.push_back(mk(1, 0, 3'd0, 32'd0,         4'h0, 1, 32'h0000_0000));
        tbl.push_back(mk(1, 1, 3'd3, 32'h1234_5678, 4'hF, 1, 32'hA500_A5A5));
        tbl.push_back(mk(1, 0, 3'd3, 32'd0,         4'h0, 1, 32'hA500_A5A5));
        tbl.push_back(mk(0, 1, 3'd6, 32'h0000_0000, 4'h2, 0, 32'd0));
        tbl.push_back(mk(1, 0, 3'd6, 32'd0,         4'h0, 1, 32'h0000_0001));
        tbl.push_back(mk(0, 1, 3'd7, 32'h0000_0000, 4'hF, 0, 32'd0));
        tbl.push_back(mk(1, 0, 3'd7, 32'd0,         4'h0, 1, 32'd50));
        foreach (tbl[i]) begin
            drive(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].b);
            step();
            if (tbl[i].chk) check($sformatf("tbl[%0d]", i), 64'(readdata[0]), 64'(tbl[i].exp));
        end

        // Coherent LO/HI reads across the 32-bit carry.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            sample = mdl_uptime(2);
            drive(2, 1, 0, 3'd4, 32'd0, 4'd0); step();
            lo = readdata[2];
            drive(2, 1, 0, 3'd5, 32'd0, 4'd0); step();
            hi = readdata[2];
            check($sformatf("coherent[%0d]", i), {hi, lo}, sample);
        end

        // 33-bit wrap sets OVF; write-1-to-clear.
        do_reset();
        for (int i = 0; i < 40 && mdl_uptime(3) != 64'd1; i++) step();
        drive(3, 1, 0, 3'd6, 32'd0, 4'd0); step();
        check("ovf_set", 64'(readdata[3]), 64'h101);
        drive(3, 0, 1, 3'd6, 32'h100, 4'b0010); step();
        drive(3, 1, 0, 3'd6, 32'd0, 4'd0); step();
        check("ovf_cleared", 64'(readdata[3]), 64'h001);

        // OVF clear landing on the wrap edge.
        do_reset();
        for (int i = 0; i < 40 && mdl_uptime(3) != mask(3); i++) step();
        drive(3, 0, 1, 3'd6, 32'h100, 4'b0010); step();
        drive(3, 1, 0, 3'd6, 32'd0, 4'd0); step();
        check("ovf_set_wins", 64'(readdata[3]), 64'h101);

        // Randomised traffic on all instances.
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < NI; k++) begin
                int op;
                logic [2:0] a;
                logic [31:0] d;
                op = $urandom_range(0, 9);
                a  = 3'($urandom_range(0, 7));
                d  = $urandom;
                if (a == 3'd6) begin
                    d[0] = ($urandom_range(0, 3) != 0);
                    d[1] = ($urandom_range(0, 7) == 0);
                end
                if (op <= 3)      drive(k, 1, 0, a, 32'd0, 4'd0);
                else if (op <= 6) drive(k, 0, 1, a, d, 4'($urandom));
                else if (op == 7) drive(k, 1, 1, a, d, 4'($urandom));
            end
            step();
        end

        // Reset asserted while a read is in flight.
        drive(0, 0, 1, 3'd3, 32'hDEAD_BEEF, 4'hF); step();
        drive(0, 0, 1, 3'd6, 32'h0, 4'h1); step();
        drive(0, 1, 0, 3'd3, 32'd0, 4'd0);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_rdv", 64'(rdv[0]), 64'd0);
        check("midrst_readdata", 64'(readdata[0]), 64'd0);
        @(posedge clock);
        #1;
        check("midrst_rdv_edge", 64'(rdv[0]), 64'd0);
        idle_all();
        model_init();
        reset_n = 1'b1;
        drive(0, 1, 0, 3'd3, 32'd0, 4'd0); step();
        check("midrst_scratch", 64'(readdata[0]), 64'd0);
        drive(0, 1, 0, 3'd6, 32'd0, 4'd0); step();
        check("midrst_ctrl", 64'(readdata[0]), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
